sound_player: RTL and testbench

SOUND_PLAYER -- requirements
Module: sound_player

---
 rtl/sound_player_pkg.sv | 27 ++
 rtl/sound_player_sync2.sv | 21 ++
 rtl/sound_player.sv | 129 ++++++++++++
 tb/tb_sound_player.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sound_player_pkg.sv
// Shared definitions for the sound player: sound codes, FSM states and
// the elaboration-time helpers used to size the tone counters.
package sound_player_pkg;

   localparam logic [1:0] CODE_STOP = 2'b00;
   localparam logic [1:0] CODE_PONG = 2'b01;
   localparam logic [1:0] CODE_PING = 2'b10;
   localparam logic [1:0] CODE_GO   = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      NOTE1 = 2'b01,
      NOTE2 = 2'b10
   } state_t;

   // Clamped to one cycle so an absurd tone request cannot yield a zero half period.
   function automatic int half_cycles(input int clk_hz, input int tone_hz);
      int h;
      h = clk_hz / (2 * tone_hz);
      return (h < 1) ? 1 : h;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sound_player_sync2.sv
// Two-flop synchroniser for one asynchronous input bit, cleared to 0 on reset.
module sync2 (
   input  logic clk,
   input  logic clr_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/sound_player.sv
// Buzzer sequencer: a change on the synchronised sound code starts (or aborts)
// a fixed-length square-wave note; the go code chains a second, higher note.
module sound_player
   import sound_player_pkg::*;
#(
   parameter int CLK_HZ  = 12_000_000,
   parameter int PING_HZ = 1000,
   parameter int PONG_HZ = 500,
   parameter int GO1_HZ  = 750,
   parameter int GO2_HZ  = 1500,
   parameter int DUR_CYC = 1_200_000
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic [1:0] code_sound,
   input  logic       mute,
   output logic       speaker,
   output logic       busy
);

   localparam int HALF_PING = half_cycles(CLK_HZ, PING_HZ);
   localparam int HALF_PONG = half_cycles(CLK_HZ, PONG_HZ);
   localparam int HALF_GO1  = half_cycles(CLK_HZ, GO1_HZ);
   localparam int HALF_GO2  = half_cycles(CLK_HZ, GO2_HZ);
   localparam int HALF_MAX  = max_int(max_int(HALF_PING, HALF_PONG), max_int(HALF_GO1, HALF_GO2));
   localparam int HALF_W    = $clog2(HALF_MAX) + 1;
   localparam int DUR_W     = $clog2(DUR_CYC) + 1;

   localparam logic [HALF_W-1:0] PING_LAST = HALF_W'(HALF_PING - 1);
   localparam logic [HALF_W-1:0] PONG_LAST = HALF_W'(HALF_PONG - 1);
   localparam logic [HALF_W-1:0] GO1_LAST  = HALF_W'(HALF_GO1 - 1);
   localparam logic [HALF_W-1:0] GO2_LAST  = HALF_W'(HALF_GO2 - 1);
   localparam logic [DUR_W-1:0]  DUR_LAST  = DUR_W'(DUR_CYC - 1);

   logic [1:0]        code_sync;
   logic [1:0]        prev_code;
   logic [1:0]        note_code;
   logic              mute_sync;
   logic              trigger;
   logic [HALF_W-1:0] trig_half_last;
   logic [HALF_W-1:0] half_last;
   logic [HALF_W-1:0] half_cnt;
   logic [DUR_W-1:0]  dur_cnt;
   logic              tone;
   state_t            state;

   for (genvar i = 0; i < 2; i++) begin : g_code_sync
      sync2 u_sync (.clk(clk), .clr_n(clr_n), .d(code_sound[i]), .q(code_sync[i]));
   end

   sync2 u_mute_sync (.clk(clk), .clr_n(clr_n), .d(mute), .q(mute_sync));

   assign trigger = (code_sync != prev_code);

   always_comb begin
      trig_half_last = GO1_LAST;
      case (code_sync)
         CODE_PONG: trig_half_last = PONG_LAST;
         CODE_PING: trig_half_last = PING_LAST;
         default:   trig_half_last = GO1_LAST;
      endcase
   end

   // Outputs are registered from the same next-state decisions as the state
   // itself, so busy and speaker rise on the very edge the note begins.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state     <= IDLE;
         prev_code <= CODE_STOP;
         note_code <= CODE_STOP;
         half_last <= '0;
         half_cnt  <= '0;
         dur_cnt   <= '0;
         tone      <= 1'b0;
         speaker   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         prev_code <= code_sync;
         if (trigger) begin
            dur_cnt  <= '0;
            half_cnt <= '0;
            if (code_sync == CODE_STOP) begin
               state   <= IDLE;
               tone    <= 1'b0;
               busy    <= 1'b0;
               speaker <= 1'b0;
            end else begin
               state     <= NOTE1;
               note_code <= code_sync;
               half_last <= trig_half_last;
               tone      <= 1'b1;
               busy      <= 1'b1;
               speaker   <= ~mute_sync;
            end
         end else if (state != IDLE) begin
            if (dur_cnt == DUR_LAST) begin
               dur_cnt  <= '0;
               half_cnt <= '0;
               if (state == NOTE1 && note_code == CODE_GO) begin
                  state     <= NOTE2;
                  half_last <= GO2_LAST;
                  tone      <= 1'b1;
                  busy      <= 1'b1;
                  speaker   <= ~mute_sync;
               end else begin
                  state   <= IDLE;
                  tone    <= 1'b0;
                  busy    <= 1'b0;
                  speaker <= 1'b0;
               end
            end else begin
               dur_cnt <= dur_cnt + DUR_W'(1);
               if (half_cnt == half_last) begin
                  half_cnt <= '0;
                  tone     <= ~tone;
                  speaker  <= ~tone & ~mute_sync;
               end else begin
                  half_cnt <= half_cnt + HALF_W'(1);
                  speaker  <= tone & ~mute_sync;
               end
            end
         end else begin
            busy    <= 1'b0;
            speaker <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sound_player.sv
// Directed bench for sound_player with scaled-down tones; one task per scenario,
// outputs sampled 1 time unit after each rising edge.
module tb_sound_player;

   logic       clk = 1'b0;
   logic       clr_n = 1'b0;
   logic [1:0] code_sound = 2'b00;
   logic       mute = 1'b0;
   logic       speaker;
   logic       busy;

   int checks = 0;
   int failures = 0;

   sound_player #(
      .CLK_HZ(1000), .PING_HZ(100), .PONG_HZ(50),
      .GO1_HZ(25), .GO2_HZ(100), .DUR_CYC(40)
   ) dut (
      .clk(clk), .clr_n(clr_n), .code_sound(code_sound),
      .mute(mute), .speaker(speaker), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic step_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic settle_idle();
      code_sound = 2'b00;
      repeat (5) step_edge();
   endtask

   task automatic test_reset();
      clr_n = 1'b0;
      code_sound = 2'b00;
      repeat (3) step_edge();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
      checks++;
      if (speaker !== 1'b0) begin failures++; $display("[TB] FAIL reset_speaker got=%b exp=0", speaker); end
      clr_n = 1'b1;
      repeat (5) step_edge();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_idle got=%b exp=0", busy); end
   endtask

   task automatic test_ping();
      logic exp_spk;
      code_sound = 2'b10;
      repeat (2) step_edge();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ping_early_busy got=%b exp=0", busy); end
      for (int k = 0; k < 40; k++) begin
         step_edge();
         exp_spk = ((k / 5) % 2) == 0;
         checks++;
         if (busy !== 1'b1) begin failures++; $display("[TB] FAIL ping_busy k=%0d got=%b exp=1", k, busy); end
         checks++;
         if (speaker !== exp_spk) begin failures++; $display("[TB] FAIL ping_speaker k=%0d got=%b exp=%b", k, speaker, exp_spk); end
      end
      step_edge();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ping_end_busy got=%b exp=0", busy); end
      checks++;
      if (speaker !== 1'b0) begin failures++; $display("[TB] FAIL ping_end_speaker got=%b exp=0", speaker); end
      settle_idle();
   endtask

   task automatic test_go();
      logic exp_spk;
      code_sound = 2'b11;
      repeat (2) step_edge();
      for (int k = 0; k < 80; k++) begin
         step_edge();
         exp_spk = (k < 40) ? (((k / 20) % 2) == 0) : ((((k - 40) / 5) % 2) == 0);
         checks++;
         if (busy !== 1'b1) begin failures++; $display("[TB] FAIL go_busy k=%0d got=%b exp=1", k, busy); end
         checks++;
         if (speaker !== exp_spk) begin failures++; $display("[TB] FAIL go_speaker k=%0d got=%b exp=%b", k, speaker, exp_spk); end
      end
      step_edge();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL go_end_busy got=%b exp=0", busy); end
      checks++;
      if (speaker !== 1'b0) begin failures++; $display("[TB] FAIL go_end_speaker got=%b exp=0", speaker); end
      settle_idle();
   endtask

   task automatic test_back_to_back();
      logic exp_spk;
      code_sound = 2'b10;
      repeat (2) step_edge();
      // Pong is requested after note cycle 12 and takes over at cycle 15.
      for (int k = 0; k < 55; k++) begin
         step_edge();
         exp_spk = (k < 15) ? (((k / 5) % 2) == 0) : ((((k - 15) / 10) % 2) == 0);
         checks++;
         if (busy !== 1'b1) begin failures++; $display("[TB] FAIL retrig_busy k=%0d got=%b exp=1", k, busy); end
         checks++;
         if (speaker !== exp_spk) begin failures++; $display("[TB] FAIL retrig_speaker k=%0d got=%b exp=%b", k, speaker, exp_spk); end
         if (k == 12) code_sound = 2'b01;
      end
      step_edge();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL retrig_end_busy got=%b exp=0", busy); end
      settle_idle();
   endtask

   task automatic test_mute();
      logic exp_spk;
      code_sound = 2'b10;
      repeat (2) step_edge();
      for (int k = 0; k < 40; k++) begin
         step_edge();
         exp_spk = ((((k / 5) % 2) == 0) && !(k >= 10 && k <= 22));
         checks++;
         if (busy !== 1'b1) begin failures++; $display("[TB] FAIL mute_busy k=%0d got=%b exp=1", k, busy); end
         checks++;
         if (speaker !== exp_spk) begin failures++; $display("[TB] FAIL mute_speaker k=%0d got=%b exp=%b", k, speaker, exp_spk); end
         if (k == 7) mute = 1'b1;
         if (k == 20) mute = 1'b0;
      end
      step_edge();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mute_end_busy got=%b exp=0", busy); end
      settle_idle();
   endtask

   task automatic test_abort();
      logic exp_spk;
      logic exp_busy;
      code_sound = 2'b10;
      repeat (2) step_edge();
      for (int k = 0; k < 12; k++) begin
         step_edge();
         exp_busy = (k < 8);
         exp_spk  = (k < 8) && (((k / 5) % 2) == 0);
         checks++;
         if (busy !== exp_busy) begin failures++; $display("[TB] FAIL abort_busy k=%0d got=%b exp=%b", k, busy, exp_busy); end
         checks++;
         if (speaker !== exp_spk) begin failures++; $display("[TB] FAIL abort_speaker k=%0d got=%b exp=%b", k, speaker, exp_spk); end
         if (k == 5) code_sound = 2'b00;
      end
      settle_idle();
   endtask

   task automatic test_reset_mid();
      logic exp_spk;
      code_sound = 2'b01;
      repeat (2) step_edge();
      for (int k = 0; k < 10; k++) begin
         step_edge();
         checks++;
         if (speaker !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_pre_speaker k=%0d got=%b exp=1", k, speaker); end
      end
      clr_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_async_busy got=%b exp=0", busy); end
      checks++;
      if (speaker !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_async_speaker got=%b exp=0", speaker); end
      repeat (2) step_edge();
      clr_n = 1'b1;
      repeat (2) step_edge();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_early_busy got=%b exp=0", busy); end
      for (int m = 0; m < 40; m++) begin
         step_edge();
         exp_spk = ((m / 10) % 2) == 0;
         checks++;
         if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_busy m=%0d got=%b exp=1", m, busy); end
         checks++;
         if (speaker !== exp_spk) begin failures++; $display("[TB] FAIL rstmid_speaker m=%0d got=%b exp=%b", m, speaker, exp_spk); end
      end
      for (int m = 0; m < 10; m++) begin
         step_edge();
         checks++;
         if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_once_busy m=%0d got=%b exp=0", m, busy); end
      end
   endtask

   initial begin
      test_reset();
      test_ping();
      test_go();
      test_back_to_back();
      test_mute();
      test_abort();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
